muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO register width; only 32 is required to be supported.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 Start  input  1  issue strobe from the execute stage, sampled on rising edge.
REQ-005 Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-006 Rdata1  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
REQ-007 Rdata2  input  WIDTH  rt operand (multiplier / divisor).
REQ-008 Busy  output  1  unit occupied; new Start is ignored while high.
REQ-009 Done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
REQ-010 HI  output  WIDTH  HI register (product upper half / remainder).
REQ-011 LO  output  WIDTH  LO register (product lower half / quotient).

Function
REQ-012 States SHALL be IDLE, MUL, DIV, FIX, DONE; the implementation SHALL have no other reachable states.
REQ-013 Accept edge E0: Start=1 and Busy=0 in IDLE or DONE; Op and operands SHALL be latched at E0 and SHALL NOT be re-sampled afterwards.
REQ-014 MTHI/MTLO SHALL write Rdata1 to HI/LO at E0, leave the other register unchanged, keep Busy=0, and not pulse Done.
REQ-015 Reserved Op values with Start=1 SHALL be ignored: no state change, no output change.
REQ-016 For signed ops, operand magnitudes SHALL be latched together with the result signs; unsigned ops SHALL use operands as-is.
REQ-017 MUL SHALL be a shift-add iteration over one multiplier bit per cycle, running for 32 cycles (E1..E32). A 64-bit accumulator SHALL hold the partial product.
REQ-018 DIV SHALL be a restoring division producing one quotient bit per cycle, running for 32 cycles (E1..E32).
REQ-019 FIX at E33 SHALL apply sign correction and write {HI,LO}:
  - Product: the 64-bit product is negated when the operand signs differ.
  - Quotient: truncates toward zero.
  - Remainder: takes the sign of the dividend.
REQ-020 DONE: Done=1 for the single cycle after E33, with Busy=0 in that cycle; the state then returns to IDLE unless a new Start is accepted in that cycle.
REQ-021 Busy SHALL be 1 from the cycle after E0 through the cycle before Done.
REQ-022 Result latency SHALL be 34 cycles from E0 to the first cycle with Done=1.
REQ-023 HI/LO SHALL hold their previous values until the FIX write; intermediate iteration values SHALL never be visible on HI/LO.
REQ-024 Divide by zero (DIV or DIVU with Rdata2=0) SHALL skip iteration:
  - Busy=1 for exactly one cycle.
  - Done pulses in the cycle after E1.
  - HI/LO stay unchanged.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000, with no trap.
REQ-026 Start=1 while Busy=1 SHALL be ignored entirely; the in-flight operation SHALL complete unaffected.
REQ-027 A Start accepted in the DONE cycle SHALL begin a new operation with no idle gap.

Reset
REQ-028 RST=0 SHALL immediately and asynchronously force state=IDLE, HI=0, LO=0, Busy=0, Done=0, and clear the accumulator and counter.
REQ-029 RST asserted mid-operation SHALL abort the operation; no Done SHALL pulse for the aborted operation after RST deasserts.
REQ-030 The first Start SHALL be accepted on the first rising edge with RST=1.

Verification
REQ-031 MULT 0xFFFFFFFD x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB, Done in cycle 34 after E0, HI/LO unchanged before that.
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; back-to-back MULTU 2x3 issued in the Done cycle -> LO=6, HI=0.
REQ-033 DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 Preload HI=0x11111111, LO=0x22222222 via MTHI/MTLO, then DIVU 100/0 -> Done one cycle after E1, HI/LO unchanged; MTHI shows Busy=0 and no Done.
REQ-035 Start DIVU 100/7 while a MULT is Busy -> ignored; MULT result correct. New DIVU 100/7 -> LO=14, HI=2.
REQ-036 RST low at iteration 10 of a MULT -> HI=LO=0 and Busy=0 immediately; no Done after release; a subsequent MULTU 5x5 -> LO=25.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: shift-add multiply and
// restoring divide, one bit per cycle, with a final sign-correction cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] Rdata1,
    input  logic [WIDTH-1:0] Rdata2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               div0;
    logic               neg_res;
    logic               neg_rem;

    logic               accept;
    logic               sgn_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   trial;
    logic               q_bit;
    logic [WIDTH-1:0]   new_rem;
    logic [2*WIDTH-1:0] div_nxt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    always_comb begin
        accept = Start && (state == S_IDLE || state == S_DONE) && (Op[2:1] != 2'b11);
        sgn_op = ~Op[0];
        a_neg  = sgn_op && Rdata1[WIDTH-1];
        b_neg  = sgn_op && Rdata2[WIDTH-1];
        a_mag  = a_neg ? -Rdata1 : Rdata1;
        b_mag  = b_neg ? -Rdata2 : Rdata2;
    end

    // Multiplier sits in acc's low half and shifts out as the product shifts in.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_nxt = {mul_sum, acc[WIDTH-1:1]};
    end

    // Dividend shifts out of acc's low half while quotient bits shift in.
    always_comb begin
        rem_sh  = acc[2*WIDTH-1:WIDTH-1];
        trial   = {1'b0, rem_sh} - {2'b00, opb};
        q_bit   = ~trial[WIDTH+1];
        new_rem = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        div_nxt = {new_rem, acc[WIDTH-2:0], q_bit};
    end

    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        q_fix    = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix    = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                Done      = (state == S_DONE);
                state_nxt = S_IDLE;
                if (accept && !Op[2]) begin
                    state_nxt = Op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                Busy = 1'b1;
                if (cnt == LAST) state_nxt = S_FIX;
            end
            S_DIV: begin
                Busy = 1'b1;
                if (div0) state_nxt = S_DONE;
                else if (cnt == LAST) state_nxt = S_FIX;
            end
            S_FIX: begin
                Busy      = 1'b1;
                state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc     <= '0;
            opb     <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            div0    <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (!Op[2]) begin
                            cnt     <= '0;
                            is_div  <= Op[1];
                            div0    <= Op[1] && (Rdata2 == '0);
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            if (Op[1]) begin
                                acc <= {{WIDTH{1'b0}}, a_mag};
                                opb <= b_mag;
                            end else begin
                                acc <= {{WIDTH{1'b0}}, b_mag};
                                opb <= a_mag;
                            end
                        end else if (Op == OP_MTHI) begin
                            HI <= Rdata1;
                        end else if (Op == OP_MTLO) begin
                            LO <= Rdata1;
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_nxt;
                    cnt <= cnt + 1'b1;
                end
                S_DIV: begin
                    if (!div0) begin
                        acc <= div_nxt;
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        HI <= r_fix;
                        LO <= q_fix;
                    end else begin
                        HI <= prod_fix[2*WIDTH-1:WIDTH];
                        LO <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, HI/LO hold, divide-by-zero,
// busy-ignore, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_RSV   = 3'b110;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Op = '0;
    logic [31:0] Rdata1 = '0;
    logic [31:0] Rdata2 = '0;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int tests = 0;
    int failed = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Op(Op),
        .Rdata1(Rdata1), .Rdata2(Rdata2),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives the request through its accept edge, then scrambles the operand bus.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start  = 1'b1;
        Op     = op;
        Rdata1 = a;
        Rdata2 = b;
        tick();
        Start  = 1'b0;
        Op     = OP_RSV;
        Rdata1 = $urandom;
        Rdata2 = $urandom;
    endtask

    task automatic wait_done(input string tag, input int n0, input int exp_lat);
        int n;
        int bad;
        n = n0;
        bad = 0;
        while (!Done && n < 100) begin
            if (HI !== m_hi || LO !== m_lo || Busy !== 1'b1) bad++;
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_hold"}, 64'(bad), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        issue(op, a, b);
        wait_done(tag, 1, 34);
        check({tag, "_res"}, {HI, LO}, {eh, el});
        check({tag, "_done_busy"}, {63'd0, Busy}, 64'd0);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        int dcnt;
        #2;
        check("rst_hilo", {HI, LO}, 64'd0);
        check("rst_flags", {62'd0, Busy, Done}, 64'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("multu_b2b", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

        tick();
        check("idle_after_done", {62'd0, Busy, Done}, 64'd0);
        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("div_negdiv", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);

        tick();
        issue(OP_MTHI, 32'h11111111, 32'h0);
        check("mthi_val", {HI, LO}, {32'h11111111, m_lo});
        check("mthi_flags", {62'd0, Busy, Done}, 64'd0);
        m_hi = 32'h11111111;
        issue(OP_MTLO, 32'h22222222, 32'h0);
        check("mtlo_val", {HI, LO}, {32'h11111111, 32'h22222222});
        check("mtlo_flags", {62'd0, Busy, Done}, 64'd0);
        m_lo = 32'h22222222;

        issue(OP_RSV, 32'hDEADBEEF, 32'h1);
        check("rsv_val", {HI, LO}, {m_hi, m_lo});
        check("rsv_flags", {62'd0, Busy, Done}, 64'd0);

        issue(OP_DIVU, 32'd100, 32'd0);
        check("dz_c1", {62'd0, Busy, Done}, 64'b10);
        tick();
        check("dz_c2", {62'd0, Busy, Done}, 64'b01);
        check("dz_hilo", {HI, LO}, {32'h11111111, 32'h22222222});
        tick();

        issue(OP_MULT, 32'h00001234, 32'hFFFFFFFE);
        repeat (5) tick();
        Start  = 1'b1;
        Op     = OP_DIVU;
        Rdata1 = 32'd100;
        Rdata2 = 32'd7;
        repeat (3) tick();
        Start  = 1'b0;
        wait_done("busy_ign", 9, 34);
        check("busy_ign_res", {HI, LO}, 64'hFFFFFFFF_FFFFDB98);
        m_hi = 32'hFFFFFFFF;
        m_lo = 32'hFFFFDB98;
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        tick();
        issue(OP_MULT, 32'h12345678, 32'h9ABCDEF0);
        repeat (9) tick();
        RST = 1'b0;
        #1;
        check("rst_mid_hilo", {HI, LO}, 64'd0);
        check("rst_mid_flags", {62'd0, Busy, Done}, 64'd0);
        tick();
        tick();
        RST = 1'b1;
        m_hi = '0;
        m_lo = '0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done !== 1'b0 || Busy !== 1'b0) dcnt++;
            tick();
        end
        check("rst_no_done", 64'(dcnt), 64'd0);
        run_op("multu_5x5", OP_MULTU, 32'd5, 32'd5, 32'd0, 32'd25);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
